// File: rtl/flag_buf_fifo.sv
// flag_buf_fifo: FWFT word buffer with flag/full/count/sticky-overrun status; ports clk, reset, set_flag (push), clr_flag (pop), clr_ovr, din -> flag, full, dout, count, overrun; define FLAG_BUF_OVERWRITE_EN to overwrite the oldest word on push-while-full
module flag_buf_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_flag,
  input  logic              clr_flag,
  input  logic              clr_ovr,
  input  logic [DATA_W-1:0] din,
  output logic              flag,
  output logic              full,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W:0]   count,
  output logic              overrun
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
`ifdef FLAG_BUF_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic              pop_ok, ovr_ev, wr_en, rd_adv;
  logic [ADDR_W:0]   count_nxt;
  always_comb begin
    pop_ok    = clr_flag && flag;
    ovr_ev    = set_flag && !clr_flag && full;
    wr_en     = set_flag && (!full || clr_flag || OVW);
    rd_adv    = pop_ok || (OVW && ovr_ev);
    count_nxt = count + (ADDR_W+1)'(wr_en && !rd_adv) - (ADDR_W+1)'(rd_adv && !wr_en);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      flag    <= 1'b0;
      full    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) mem[wr_ptr] <= din;
      wr_ptr  <= wr_en ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr  <= rd_adv ? rd_ptr + 1'b1 : rd_ptr;
      count   <= count_nxt;
      flag    <= count_nxt != '0;
      full    <= count_nxt == DEPTH;
      overrun <= ovr_ev ? 1'b1 : clr_ovr ? 1'b0 : overrun;
    end
  end
  assign dout = flag ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_flag_buf_fifo.sv
// tb_flag_buf_fifo: randomized scoreboard bench for flag_buf_fifo against a queue-based reference model
module tb_flag_buf_fifo;
  localparam int DEPTH = 4;
  logic       clk = 1'b0;
  logic       reset = 1'b1, set_flag = 1'b0, clr_flag = 1'b0, clr_ovr = 1'b0;
  logic [7:0] din = '0;
  logic       flag, full, overrun;
  logic [7:0] dout;
  logic [2:0] count;
  typedef struct packed {
    logic       flag;
    logic       full;
    logic [2:0] count;
    logic [7:0] dout;
    logic       ovr;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] model_q[$];
  logic       model_ovr = 1'b0;
  int         tests = 0, fails = 0;
  flag_buf_fifo #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .set_flag(set_flag), .clr_flag(clr_flag),
    .clr_ovr(clr_ovr), .din(din), .flag(flag), .full(full), .dout(dout),
    .count(count), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("flag", 32'(flag), 32'(e.flag));
      check("full", 32'(full), 32'(e.full));
      check("count", 32'(count), 32'(e.count));
      check("dout", 32'(dout), 32'(e.dout));
      check("overrun", 32'(overrun), 32'(e.ovr));
    end
  end
  task automatic step(input logic r, input logic s, input logic c, input logic co, input logic [7:0] d);
    logic ev;
    exp_t e;
    @(negedge clk);
    reset = r; set_flag = s; clr_flag = c; clr_ovr = co; din = d;
    if (r) begin
      model_q.delete();
      model_ovr = 1'b0;
    end else begin
      ev = s && !c && model_q.size() == DEPTH;
      if (s && c && model_q.size() != 0) begin
        void'(model_q.pop_front());
        model_q.push_back(d);
      end else if (s) begin
        if (model_q.size() < DEPTH) model_q.push_back(d);
`ifdef FLAG_BUF_OVERWRITE_EN
        else begin
          void'(model_q.pop_front());
          model_q.push_back(d);
        end
`endif
      end else if (c && model_q.size() != 0) void'(model_q.pop_front());
      model_ovr = ev ? 1'b1 : co ? 1'b0 : model_ovr;
    end
    e.flag  = model_q.size() != 0;
    e.full  = model_q.size() == DEPTH;
    e.count = 3'(model_q.size());
    e.dout  = model_q.size() != 0 ? model_q[0] : 8'h00;
    e.ovr   = model_ovr;
    exp_q.push_back(e);
  endtask
  task automatic push(input logic [7:0] d); step(0, 1, 0, 0, d); endtask
  task automatic pop(); step(0, 0, 1, 0, 8'h00); endtask
  task automatic idle(); step(0, 0, 0, 0, 8'h00); endtask
  initial begin
    step(1, 0, 0, 0, 8'h00);
    repeat (3) idle();
    push(8'hA1);
    pop();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    push(8'h55);
    repeat (4) pop();
    step(0, 0, 0, 1, 8'h00);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    step(0, 1, 1, 0, 8'h66);
    repeat (4) pop();
    step(0, 1, 1, 0, 8'h77);
    pop();
    pop();
    repeat (4) push(8'hC0);
    push(8'hC5);
    step(0, 0, 0, 1, 8'h00);
    idle();
    repeat (4) push(8'hB0);
    push(8'hB5);
    pop();
    step(1, 1, 0, 0, 8'hEE);
    idle();
    for (int i = 0; i < 2000; i++)
      step($urandom_range(63) == 0, $urandom_range(99) < 50, $urandom_range(99) < 40,
           $urandom_range(15) == 0, 8'($urandom));
    idle();
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
